spi: RTL and testbench



---
 rtl/spi.sv | 120 ++++++++++++
 tb/tb_spi.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/spi.sv
// rtl/spi.sv - byte-oriented SPI mode-0 slave with oversampled pin synchronizers
//
// Purpose: receives one byte MSB-first from an off-chip SPI master while shifting
// out a locally supplied reply byte. All SPI pins are oversampled in clk domain.
//
// Ports:
//   clk   in   system clock, rising-edge
//   rst   in   asynchronous active-high reset
//   sck   in   SPI clock from master (idles low)
//   ss    in   slave select, active-low
//   mosi  in   serial data from master
//   miso  out  serial data to master (0 while deselected)
//   dout  in   [7:0] reply byte, sampled at byte boundaries
//   din   out  [7:0] last complete byte received
//   done  out  one-clk pulse when din updates
//
// Configuration macro: SPI_SYNC3_EN - 3-flop input synchronizers instead of 2.

module spi (
    input  logic       clk,
    input  logic       rst,
    input  logic       sck,
    input  logic       ss,
    input  logic       mosi,
    output logic       miso,
    input  logic [7:0] dout,
    output logic [7:0] din,
    output logic       done
);

`ifdef SPI_SYNC3_EN
    localparam int SYNC_LEN = 3;
`else
    localparam int SYNC_LEN = 2;
`endif

    logic [SYNC_LEN-1:0] sck_sync_q;
    logic [SYNC_LEN-1:0] ss_sync_q;
    logic [SYNC_LEN-1:0] mosi_sync_q;
    logic                sck_prev_q;

    logic [2:0] bit_cnt_q,  bit_cnt_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] din_q,      din_d;
    logic       done_q,     done_d;

    logic sck_s, ss_s, mosi_s;
    logic sck_rise, sck_fall;

    assign sck_s  = sck_sync_q[SYNC_LEN-1];
    assign ss_s   = ss_sync_q[SYNC_LEN-1];
    assign mosi_s = mosi_sync_q[SYNC_LEN-1];

    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;

    // Synchronizers; ss resets high so the slave starts deselected.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync_q  <= '0;
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_LEN-2:0], sck};
            ss_sync_q   <= {ss_sync_q[SYNC_LEN-2:0], ss};
            mosi_sync_q <= {mosi_sync_q[SYNC_LEN-2:0], mosi};
            sck_prev_q  <= sck_s;
        end
    end

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        din_d      = din_q;
        done_d     = 1'b0;

        if (ss_s) begin
            // Deselected: any partial byte is dropped, reply byte tracks dout.
            bit_cnt_d  = 3'd0;
            tx_shift_d = dout;
        end else if (sck_rise) begin
            rx_shift_d = {rx_shift_q[6:0], mosi_s};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                din_d  = {rx_shift_q[6:0], mosi_s};
                done_d = 1'b1;
            end
        end else if (bit_cnt_q == 3'd0) begin
            // Byte boundary: keep reloading so bit 7 is on miso before the first rise.
            // This also swallows the trailing fall of the previous byte.
            tx_shift_d = dout;
        end else if (sck_fall) begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q  <= 3'd0;
            rx_shift_q <= 8'h00;
            tx_shift_q <= 8'h00;
            din_q      <= 8'h00;
            done_q     <= 1'b0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            din_q      <= din_d;
            done_q     <= done_d;
        end
    end

    assign miso = ss_s ? 1'b0 : tx_shift_q[7];
    assign din  = din_q;
    assign done = done_q;

endmodule

// File: tb/tb_spi.sv
// tb/tb_spi.sv - randomized self-checking bench for the spi slave

module tb_spi;

`ifdef SPI_SYNC3_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif
    localparam int PH = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sck = 1'b0;
    logic       ss = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic [7:0] dout = 8'h00;
    logic [7:0] din;
    logic       done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ss_hi_cnt = 0;

    int         exp_done_cyc[$];
    logic [7:0] exp_done_val[$];
    logic [7:0] exp_din = 8'h00;
    int         done_pulses = 0;

    spi dut (
        .clk  (clk),
        .rst  (rst),
        .sck  (sck),
        .ss   (ss),
        .mosi (mosi),
        .miso (miso),
        .dout (dout),
        .din  (din),
        .done (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        ss_hi_cnt <= ss ? ss_hi_cnt + 1 : 0;
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, req, cyc);
        end
    endtask

    // Per-cycle compare against the model's expected done/din timeline.
    always @(negedge clk) begin
        if (!rst) begin
            logic exp_done;
            exp_done = 1'b0;
            if (exp_done_cyc.size() > 0 && exp_done_cyc[0] == cyc) begin
                exp_done = 1'b1;
                exp_din  = exp_done_val[0];
                void'(exp_done_cyc.pop_front());
                void'(exp_done_val.pop_front());
            end
            if (done) done_pulses++;
            check("done_cycle", int'(done), int'(exp_done));
            check("din_cycle", int'(din), int'(exp_din));
            if (ss_hi_cnt >= LAT) check("miso_idle", int'(miso), 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic select();
        ss = 1'b0;
        tick(5);
    endtask

    task automatic deselect();
        tick(2);
        ss = 1'b1;
        tick(LAT + 4);
    endtask

    // Master sends nbits of data (MSB first) while slave should reply with reply.
    task automatic xfer(input logic [7:0] data, input logic [7:0] reply, input int nbits,
                        output logic [7:0] rx);
        dout = reply;
        tick(LAT + 2);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = data[7-i];
            tick(PH);
            sck = 1'b1;
            rx = {rx[6:0], miso};
            if (i == 7) begin
                exp_done_cyc.push_back(cyc + LAT);
                exp_done_val.push_back(data);
            end
            tick(PH);
            sck = 1'b0;
            if (i == 3) dout = 8'($urandom);  // mid-byte change must not disturb reply
            tick(1);
            check("done_after_fall", int'(done), 0);
            tick(PH - 1);
        end
    endtask

    task automatic full_byte(input logic [7:0] data, input logic [7:0] reply);
        logic [7:0] rx;
        xfer(data, reply, 8, rx);
        check("master_rx", int'(rx), int'(reply));
        tick(LAT);
        check("din_final", int'(din), int'(data));
    endtask

    initial begin
        logic [7:0] rx;
        int pulses0;

        tick(10);
        rst = 1'b0;
        tick(1);
        check("reset_din", int'(din), 8'h00);
        check("reset_done", int'(done), 0);
        check("reset_miso", int'(miso), 0);

        // Directed bytes within one ss frame, with literal pins on the model.
        select();
        xfer(8'hAA, 8'h00, 8, rx);
        check("lit_rx_00", int'(rx), 8'h00);
        tick(LAT);
        check("lit_din_AA", int'(din), 8'hAA);
        full_byte(8'hFF, 8'hAA);
        full_byte(8'h00, 8'hFF);
        xfer(8'hAA, 8'hBE, 8, rx);
        check("lit_rx_BE", int'(rx), 8'hBE);
        tick(LAT);
        check("lit_din_AA2", int'(din), 8'hAA);
        deselect();
        check("lit_miso_ss_high", int'(miso), 0);

        // Aborted 4-bit byte followed by a full 0x5A.
        pulses0 = done_pulses;
        select();
        xfer(8'hC3, 8'h11, 4, rx);
        deselect();
        check("abort_din_kept", int'(din), 8'hAA);
        select();
        full_byte(8'h5A, 8'h3C);
        deselect();
        check("lit_din_5A", int'(din), 8'h5A);
        check("abort_one_pulse", done_pulses - pulses0, 1);

        // Randomized frames with occasional aborts.
        for (int f = 0; f < 12; f++) begin
            select();
            for (int b = 0; b < int'($urandom_range(1, 3)); b++) begin
                full_byte(8'($urandom), 8'($urandom));
            end
            if ($urandom_range(0, 2) == 0) begin
                xfer(8'($urandom), 8'($urandom), int'($urandom_range(1, 7)), rx);
            end
            deselect();
        end

        tick(LAT + 2);
        check("queue_drained", exp_done_cyc.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
